// File: rtl/lsu_obi_master.sv
// lsu_obi_master
// Load/store initiator between the core memory stage and a single-outstanding
// OBI-style data port. One byte/half/word access at a time; alignment is
// checked on acceptance. The memory port has no byte enables, so byte and
// half stores are done as read-modify-write (read the word, merge, write back).
//
// Ports
//   CLK, RSTn            clock (rising edge), async active-low reset
//   req_i                access request, sampled only in IDLE
//   we_i                 1 = store, 0 = load
//   size_i               00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i           loads: 1 = zero-extend, 0 = sign-extend
//   addr_i               byte address
//   wdata_i              store data, right-aligned
//   busy_o               transaction in progress (stall)
//   done_o               one-cycle completion pulse
//   err_o                one-cycle error pulse with done_o
//   rdata_o              extended load result, held until next load completes
//   proc_req_o           bus request
//   we_o                 bus write enable
//   addr_o               bus address, word aligned
//   wdata_o              bus write data (full word)
//   mem_rdy_i            grant; accepted when proc_req_o and mem_rdy_i are 1
//   rdata_i              bus read data, valid with valid_i
//   valid_i              bus response strobe (reads and writes)
//
// state  | meaning
// IDLE   | waiting for req_i; done_o of the previous access shows here
// RD_REQ | read request on the bus, waiting for grant
// RD_RSP | read granted, waiting for valid_i
// WR_REQ | write request on the bus, waiting for grant
// WR_RSP | write granted, waiting for valid_i
// ERR    | rejected access, done_o/err_o high for this one cycle

module lsu_obi_master (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        proc_req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        mem_rdy_i,
  input  logic [31:0] rdata_i,
  input  logic        valid_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_RSP = 3'd2,
    WR_REQ = 3'd3,
    WR_RSP = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        st_q;
  logic [1:0]  off_q;
  logic [15:0] wd_q;

  logic        bad_access;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;
  logic [31:0] st_merge;

  assign busy_o = (state != IDLE);

  assign bad_access = (size_i == 2'b11) ||
                      ((size_i == 2'b01) && addr_i[0]) ||
                      ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));

  // Lane extraction for loads and lane merge for sub-word stores, both taken
  // from the word currently on rdata_i.
  always_comb begin
    lane_b = rdata_i[{off_q, 3'b000} +: 8];
    lane_h = rdata_i[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   ld_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_ext = rdata_i;
    endcase
    st_merge = rdata_i;
    if (size_q == 2'b00)
      st_merge[{off_q, 3'b000} +: 8] = wd_q[7:0];
    else
      st_merge[{off_q[1], 4'b0000} +: 16] = wd_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      st_q       <= 1'b0;
      off_q      <= 2'b00;
      wd_q       <= 16'h0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      rdata_o    <= 32'h0;
      proc_req_o <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= 32'h0;
      wdata_o    <= 32'h0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            size_q <= size_i;
            uns_q  <= unsigned_i;
            st_q   <= we_i;
            off_q  <= addr_i[1:0];
            wd_q   <= wdata_i[15:0];
            if (bad_access) begin
              state  <= ERR;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else if (we_i && (size_i == 2'b10)) begin
              state      <= WR_REQ;
              proc_req_o <= 1'b1;
              we_o       <= 1'b1;
              addr_o     <= {addr_i[31:2], 2'b00};
              wdata_o    <= wdata_i;
            end else begin
              // loads and the read half of a sub-word store
              state      <= RD_REQ;
              proc_req_o <= 1'b1;
              we_o       <= 1'b0;
              addr_o     <= {addr_i[31:2], 2'b00};
            end
          end
        end
        RD_REQ: begin
          if (mem_rdy_i) begin
            state      <= RD_RSP;
            proc_req_o <= 1'b0;
          end
        end
        RD_RSP: begin
          if (valid_i) begin
            if (st_q) begin
              state      <= WR_REQ;
              proc_req_o <= 1'b1;
              we_o       <= 1'b1;
              wdata_o    <= st_merge;
            end else begin
              state   <= IDLE;
              rdata_o <= ld_ext;
              done_o  <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (mem_rdy_i) begin
            state      <= WR_RSP;
            proc_req_o <= 1'b0;
          end
        end
        WR_RSP: begin
          if (valid_i) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_obi_master.sv
// Testbench for lsu_obi_master. Stimulus pushes the expected completion into a
// scoreboard and the expected bus beats into a beat queue; a memory responder
// checks each bus request against the beat queue, and a monitor checks every
// done_o pulse against the scoreboard.

module tb_lsu_obi_master;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        proc_req_o, we_o;
  logic [31:0] addr_o, wdata_o;
  logic        mem_rdy_i;
  logic [31:0] rdata_i;
  logic        valid_i;
  logic        mem_valid, spurious;

  assign valid_i = mem_valid | spurious;

  lsu_obi_master dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_i(req_i), .we_i(we_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .proc_req_o(proc_req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .mem_rdy_i(mem_rdy_i), .rdata_i(rdata_i), .valid_i(valid_i)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic        busy;
    logic [31:0] rdata;
    int          lat;
    int          issue;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wt;
    int          rwt;
  } beat_t;

  exp_t  sb[$];
  beat_t bus_q[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder
  initial begin
    beat_t cur;
    logic  active;
    logic  rsp_pending;
    int    wcnt, rcnt;
    active = 0; rsp_pending = 0; wcnt = 0; rcnt = 0;
    mem_rdy_i = 0; mem_valid = 0; rdata_i = 32'h0;
    cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, wt: 0, rwt: 0};
    forever begin
      @(negedge CLK);
      mem_rdy_i = 0;
      mem_valid = 0;
      if (rsp_pending) begin
        if (rcnt > 0) rcnt--;
        else begin
          mem_valid   = 1;
          rdata_i     = cur.rdata;
          rsp_pending = 0;
        end
      end
      if (proc_req_o) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_bus_req", 32'(proc_req_o), 32'h0);
            cur = '{we: we_o, addr: addr_o, wdata: wdata_o, rdata: 32'h0, wt: 0, rwt: 0};
          end else
            cur = bus_q.pop_front();
          active = 1;
          wcnt   = cur.wt;
        end
        chk("bus_we", 32'(we_o), 32'(cur.we));
        chk("bus_addr", addr_o, cur.addr);
        if (cur.we) chk("bus_wdata", wdata_o, cur.wdata);
        if (wcnt > 0) wcnt--;
        else begin
          mem_rdy_i   = 1;
          active      = 0;
          rsp_pending = 1;
          rcnt        = cur.rwt;
        end
      end
    end
  end

  // Completion monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      if (RSTn && err_o && !done_o) chk("err_without_done", 32'(err_o), 32'h0);
      if (RSTn && done_o) begin
        if (sb.size() == 0) chk("unexpected_done", 32'(done_o), 32'h0);
        else begin
          x = sb.pop_front();
          chk("err", 32'(err_o), 32'(x.err));
          chk("rdata", rdata_o, x.rdata);
          chk("busy_at_done", 32'(busy_o), 32'(x.busy));
          chk("latency", 32'(cyc - x.issue), 32'(x.lat));
        end
      end
    end
  end

  task automatic push_beat(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int wt, input int rwt);
    beat_t b;
    b = '{we: we, addr: a, wdata: wd, rdata: rd, wt: wt, rwt: rwt};
    bus_q.push_back(b);
  endtask

  // Called at a negedge; req_i is held for exactly one cycle.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e, input int lat);
    exp_t x;
    x = '{err: e, busy: e, rdata: last_rd, lat: lat, issue: cyc + 1};
    sb.push_back(x);
    we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    req_i = 1;
    @(negedge CLK);
    req_i = 0;
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] word, input logic [31:0] exp, input int wt);
    push_beat(1'b0, {a[31:2], 2'b00}, 32'h0, word, wt, 0);
    last_rd = exp;
    issue(1'b0, sz, uns, a, 32'h0, 1'b0, 2 + wt);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      if (!busy_o && sb.size() == 0 && bus_q.size() == 0) break;
      @(negedge CLK);
    end
    if (k == 60) chk("timeout_wait_idle", 32'(k), 32'h0);
  endtask

  initial begin
    RSTn = 0; req_i = 0; we_i = 0; size_i = 0; unsigned_i = 0;
    addr_i = 0; wdata_i = 0; spurious = 0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_proc_req", 32'(proc_req_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    RSTn = 1;
    @(negedge CLK);

    // word load, zero wait
    load(2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    wait_idle();
    // byte loads, lane 3, signed and unsigned
    load(2'b00, 1'b0, 32'h0000_0103, 32'h80FF_7F01, 32'hFFFF_FF80, 0);
    wait_idle();
    load(2'b00, 1'b1, 32'h0000_0103, 32'h80FF_7F01, 32'h0000_0080, 1);
    wait_idle();
    // half load, upper half, signed
    load(2'b01, 1'b0, 32'h0000_0102, 32'h80FF_7F01, 32'hFFFF_80FF, 0);
    wait_idle();
    // unsigned half from lower half, byte from lane 1 signed
    load(2'b01, 1'b1, 32'h0000_0200, 32'h1234_F00D, 32'h0000_F00D, 0);
    wait_idle();
    load(2'b00, 1'b0, 32'h0000_0201, 32'h1234_7F0D, 32'h0000_007F, 0);
    wait_idle();

    // byte store 0xAB to 0x101 over 0x11223344, read grant delayed 2 cycles
    push_beat(1'b0, 32'h0000_0100, 32'h0, 32'h1122_3344, 2, 0);
    push_beat(1'b1, 32'h0000_0100, 32'h1122_AB44, 32'h0, 0, 0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'hCDCD_CDAB, 1'b0, 6);
    wait_idle();
    // half store to upper half, zero wait
    push_beat(1'b0, 32'h0000_0100, 32'h0, 32'h1122_3344, 0, 0);
    push_beat(1'b1, 32'h0000_0100, 32'hBEEF_3344, 32'h0, 0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_BEEF, 1'b0, 4);
    wait_idle();
    // word store with one valid wait cycle
    push_beat(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 0, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 3);
    wait_idle();

    // rejected accesses: no bus traffic, rdata_o unchanged
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h5555_5555, 1'b1, 0);
    wait_idle();
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 1'b1, 0);
    wait_idle();
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0101, 32'h0, 1'b1, 0);
    wait_idle();

    // back-to-back: second load issued in the done cycle of the first
    load(2'b10, 1'b0, 32'h0000_0300, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0);
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (done_o) break;
        @(negedge CLK);
      end
      if (k == 20) chk("timeout_b2b_done", 32'(k), 32'h0);
    end
    load(2'b00, 1'b1, 32'h0000_0304, 32'h0000_00A5, 32'h0000_00A5, 0);
    wait_idle();

    // spurious valid in IDLE
    spurious = 1;
    @(negedge CLK);
    spurious = 0;
    @(negedge CLK);
    chk("spurious_busy", 32'(busy_o), 32'h0);
    chk("spurious_rdata", rdata_o, 32'h0000_00A5);

    // reset during RD_RSP, then a late valid
    push_beat(1'b0, 32'h0000_0400, 32'h0, 32'h7777_7777, 0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 0);
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (busy_o && !proc_req_o) break;
        @(negedge CLK);
      end
      if (k == 20) chk("timeout_rd_rsp", 32'(k), 32'h0);
    end
    RSTn = 0;
    void'(sb.pop_back());
    last_rd = 32'h0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'h0);
    chk("midrst_rdata", rdata_o, 32'h0);
    chk("midrst_addr", addr_o, 32'h0);
    @(negedge CLK);
    RSTn = 1;
    repeat (5) @(negedge CLK);
    chk("late_valid_busy", 32'(busy_o), 32'h0);
    chk("late_valid_rdata", rdata_o, 32'h0);

    // recovery after reset
    load(2'b01, 1'b0, 32'h0000_0500, 32'h0000_7FFF, 32'h0000_7FFF, 0);
    wait_idle();
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
